// File: rtl/adc_seq_pkg.sv
// -----------------------------------------------------------------------------
// adc_seq_pkg
// Shared types and default constants for the ADC/AGC master sequencer.
//   seq_state_t   : sequencer state encoding (IDLE=0, RUN=1, DONE=2)
//   DEF_*         : default parameter values used by adc_sequencer and its bench
// -----------------------------------------------------------------------------
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int          DEF_NUM_CH    = 2;
  localparam int          DEF_CNT_W     = 32;
  localparam int          DEF_CTRL_W    = 10;
  localparam int          DEF_AGC_W     = 12;
  localparam logic [9:0]  DEF_CTRL_INIT = 10'b0000100100;
  localparam logic [11:0] DEF_AGC_INIT  = 12'h333;
  localparam int unsigned DEF_T_LDCTRL  = 100;
  localparam int unsigned DEF_T_ENABLE  = 1000;
  localparam int unsigned DEF_T_AGC     = 1000;
  localparam int unsigned DEF_T_END     = 1_000_000_000;

endpackage

// File: rtl/adc_seq_agc_arb.sv
// -----------------------------------------------------------------------------
// adc_seq_agc_arb
// Arbitrates AGC DAC loads against the SPI busy flag. A sequence request that
// arrives while the SPI master is busy is held pending and issued on the first
// cycle agc_busy is low. agc_load is a registered one-cycle pulse and is never
// issued on two consecutive cycles.
//
// Optional feature, macro ADC_SEQ_AGC_UPDATE_EN:
//   defined   : agc_wr captures agc_wdata into a pending register; the latest
//               pending code is loaded (merged with any sequence request) on
//               the first non-busy cycle, in any sequencer state.
//   undefined : agc_wr/agc_wdata are ignored, agc_data is constant AGC_INIT.
//
// Ports:
//   clk, arstn  : clock, synchronous active-low reset
//   abort       : drop the pending sequence request and any pulse in flight
//   seq_req     : one-cycle sequence load request (T_AGC event)
//   agc_busy    : SPI transfer in progress
//   agc_wr      : runtime code write strobe
//   agc_wdata   : runtime code
//   agc_load    : one-cycle load pulse
//   agc_data    : current AGC code
//
// Handshake: a load is "accepted" by the SPI side on any cycle where
// agc_load=1; the arbiter only raises agc_load when agc_busy was sampled low.
// -----------------------------------------------------------------------------
module adc_seq_agc_arb #(
  parameter int               AGC_W    = 12,
  parameter logic [AGC_W-1:0] AGC_INIT = 12'h333
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             abort,
  input  logic             seq_req,
  input  logic             agc_busy,
  input  logic             agc_wr,
  input  logic [AGC_W-1:0] agc_wdata,
  output logic             agc_load,
  output logic [AGC_W-1:0] agc_data
);

  logic seq_pend_q;
  logic agc_load_q;
  logic upd_pend;
  logic seq_want;
  logic issue;

  assign seq_want = seq_req | seq_pend_q;
  // Back-to-back pulses are suppressed by gating on the pulse just issued;
  // the pending flags simply stay set for one more cycle.
  assign issue    = (seq_want | upd_pend) & ~agc_busy & ~agc_load_q & ~abort;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      seq_pend_q <= 1'b0;
      agc_load_q <= 1'b0;
    end else if (abort) begin
      seq_pend_q <= 1'b0;
      agc_load_q <= 1'b0;
    end else begin
      agc_load_q <= issue;
      seq_pend_q <= seq_want & ~issue;
    end
  end

  assign agc_load = agc_load_q;

`ifdef ADC_SEQ_AGC_UPDATE_EN
  logic             upd_pend_q;
  logic [AGC_W-1:0] upd_data_q;
  logic [AGC_W-1:0] agc_data_q;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      upd_pend_q <= 1'b0;
      upd_data_q <= AGC_INIT;
      agc_data_q <= AGC_INIT;
    end else begin
      if (issue && upd_pend_q) agc_data_q <= upd_data_q;
      // A write in the issue cycle is newer than the code being loaded,
      // so it stays pending for a following load.
      if (agc_wr) begin
        upd_pend_q <= 1'b1;
        upd_data_q <= agc_wdata;
      end else if (issue) begin
        upd_pend_q <= 1'b0;
      end
    end
  end

  assign upd_pend = upd_pend_q;
  assign agc_data = agc_data_q;
`else
  logic unused_agc_wr;
  assign unused_agc_wr = agc_wr ^ (^agc_wdata);
  assign upd_pend      = 1'b0;
  assign agc_data      = AGC_INIT;
`endif

endmodule

// File: rtl/adc_sequencer.sv
// -----------------------------------------------------------------------------
// adc_sequencer
// Master power-up sequencer for the ADC/AGC front end. A free-running event
// counter in RUN fires the ADC control-word load (T_LDCTRL), the ADC enable
// (T_ENABLE) and the AGC DAC load request (T_AGC); at T_END the sequence either
// stops in DONE or wraps and repeats (loop_en). The sequence starts on its own
// out of reset.
//
// Optional feature macro: ADC_SEQ_AGC_UPDATE_EN (runtime AGC code writes, see
// adc_seq_agc_arb).
//
// Ports:
//   clk, arstn    : clock, synchronous active-low reset
//   start         : restart from IDLE/DONE (ignored in RUN)
//   abort         : return to IDLE immediately; beats start and every event
//   loop_en       : repeat at T_END instead of stopping
//   ch_mask       : per-channel participation, latched at sequence start/wrap
//   agc_busy      : AGC SPI transfer in progress
//   agc_wr/wdata  : runtime AGC code write
//   adc_ldctrl    : per-channel one-cycle control-word load pulses
//   adc_enable    : per-channel enable levels
//   adc_ctrlword  : control words, channel 0 in the LSBs
//   agc_load      : one-cycle AGC load pulse
//   agc_data      : AGC code
//   done          : high in DONE
//   state         : current state (seq_state_t encoding)
//
// All event outputs are registered: an event at cnt==T shows on the outputs
// after the following clock edge.
// -----------------------------------------------------------------------------
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int                NUM_CH    = DEF_NUM_CH,
  parameter int                CNT_W     = DEF_CNT_W,
  parameter int                CTRL_W    = DEF_CTRL_W,
  parameter int                AGC_W     = DEF_AGC_W,
  parameter logic [CTRL_W-1:0] CTRL_INIT = CTRL_W'(DEF_CTRL_INIT),
  parameter logic [AGC_W-1:0]  AGC_INIT  = AGC_W'(DEF_AGC_INIT),
  parameter int unsigned       T_LDCTRL  = DEF_T_LDCTRL,
  parameter int unsigned       T_ENABLE  = DEF_T_ENABLE,
  parameter int unsigned       T_AGC     = DEF_T_AGC,
  parameter int unsigned       T_END     = DEF_T_END
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     loop_en,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     agc_busy,
  input  logic                     agc_wr,
  input  logic [AGC_W-1:0]         agc_wdata,
  output logic [NUM_CH-1:0]        adc_ldctrl,
  output logic [NUM_CH-1:0]        adc_enable,
  output logic [NUM_CH*CTRL_W-1:0] adc_ctrlword,
  output logic                     agc_load,
  output logic [AGC_W-1:0]         agc_data,
  output logic                     done,
  output logic [1:0]               state
);

  // Parameter legality, rejected at elaboration.
  if (!(T_LDCTRL < T_ENABLE)) begin : g_bad_ldctrl
    $error("adc_sequencer: T_LDCTRL must be < T_ENABLE");
  end
  if (!(T_ENABLE <= T_END)) begin : g_bad_enable
    $error("adc_sequencer: T_ENABLE must be <= T_END");
  end
  if (!(T_AGC < T_END)) begin : g_bad_agc
    $error("adc_sequencer: T_AGC must be < T_END");
  end
  if ((CNT_W < 32) && ((T_END >> CNT_W) != 0)) begin : g_bad_end
    $error("adc_sequencer: T_END does not fit in CNT_W bits");
  end

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] ldctrl_q, ldctrl_d;
  logic [NUM_CH-1:0] enable_q, enable_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;
  logic              agc_req;

  logic ev_ld, ev_en, ev_agc, ev_end;
  assign ev_ld  = (cnt_q == CNT_W'(T_LDCTRL));
  assign ev_en  = (cnt_q == CNT_W'(T_ENABLE));
  assign ev_agc = (cnt_q == CNT_W'(T_AGC));
  assign ev_end = (cnt_q == CNT_W'(T_END));

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      mask_q   <= ch_mask;
      ldctrl_q <= '0;
      enable_q <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      ldctrl_q <= ldctrl_d;
      enable_q <= enable_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    ldctrl_d = '0;
    enable_d = enable_q;
    wrap_d   = 1'b0;
    agc_req  = 1'b0;
    if (abort) begin
      state_d  = IDLE;
      cnt_d    = '0;
      enable_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d  = RUN;
            cnt_d    = '0;
            mask_d   = ch_mask;
            enable_d = '0;
          end
        end
        RUN: begin
          // After a loop wrap the enables are dropped for exactly one cycle
          // and then come straight back under the freshly latched mask.
          if (wrap_q) enable_d = mask_q;
          if (ev_ld)  ldctrl_d = mask_q;
          if (ev_en)  enable_d = mask_q;
          if (ev_agc) agc_req  = 1'b1;
          if (ev_end) begin
            if (loop_en) begin
              cnt_d    = '0;
              enable_d = '0;
              mask_d   = ch_mask;
              wrap_d   = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          cnt_d    = '0;
          enable_d = '0;
        end
      endcase
    end
    done_d = (state_d == DONE);
  end

  adc_seq_agc_arb #(
    .AGC_W    (AGC_W),
    .AGC_INIT (AGC_INIT)
  ) u_agc_arb (
    .clk       (clk),
    .arstn     (arstn),
    .abort     (abort),
    .seq_req   (agc_req),
    .agc_busy  (agc_busy),
    .agc_wr    (agc_wr),
    .agc_wdata (agc_wdata),
    .agc_load  (agc_load),
    .agc_data  (agc_data)
  );

  assign adc_ldctrl   = ldctrl_q;
  assign adc_enable   = enable_q;
  assign adc_ctrlword = {NUM_CH{CTRL_INIT}};
  assign done         = done_q;
  assign state        = state_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_sequencer
// Directed bench for adc_sequencer with T_END shortened to 2000.
// Edge numbering: edge 0 is the state right after reset; edge k is the k-th
// rising edge after arstn is released. Outputs are sampled 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_adc_sequencer;
  import adc_seq_pkg::*;

  localparam int T_END_TB = 2000;

  logic        clk = 1'b0;
  logic        arstn, start, abort, loop_en, agc_busy, agc_wr;
  logic [1:0]  ch_mask;
  logic [11:0] agc_wdata;
  logic [1:0]  adc_ldctrl, adc_enable;
  logic [19:0] adc_ctrlword;
  logic        agc_load, done;
  logic [11:0] agc_data;
  logic [1:0]  state;

  always #5 clk = ~clk;

  adc_sequencer #(.T_END(T_END_TB)) dut (
    .clk          (clk),
    .arstn        (arstn),
    .start        (start),
    .abort        (abort),
    .loop_en      (loop_en),
    .ch_mask      (ch_mask),
    .agc_busy     (agc_busy),
    .agc_wr       (agc_wr),
    .agc_wdata    (agc_wdata),
    .adc_ldctrl   (adc_ldctrl),
    .adc_enable   (adc_enable),
    .adc_ctrlword (adc_ctrlword),
    .agc_load     (agc_load),
    .agc_data     (agc_data),
    .done         (done),
    .state        (state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  int agc_pulses = 0, agc_consec = 0, ld_pulses = 0, ld_consec = 0;
  int b1_seen = 0, en_low = 0;
  logic prev_agc = 1'b0, prev_ld = 1'b0;

  typedef struct {
    int         at_edge;
    logic [1:0] ld;
    logic [1:0] en;
    logic       agc;
    logic       dn;
    logic [1:0] st;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    if (agc_load) agc_pulses++;
    if (agc_load && prev_agc) agc_consec++;
    if (adc_ldctrl != 2'b00) ld_pulses++;
    if ((adc_ldctrl != 2'b00) && prev_ld) ld_consec++;
    if (adc_ldctrl[1] | adc_enable[1]) b1_seen++;
    if (adc_enable != 2'b11) en_low++;
    prev_agc = agc_load;
    prev_ld  = (adc_ldctrl != 2'b00);
  endtask

  task automatic goto_edge(input int e);
    while (edge_n < e) step();
  endtask

  int base, a_edge, s2, busy_edge;
  logic [11:0] exp_upd;
  int          exp_upd_pulses;

  initial begin
    arstn = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    ch_mask = 2'b11; agc_busy = 1'b0; agc_wr = 1'b0; agc_wdata = '0;

    // ---------------- reset + single shot, table driven ----------------
    tbl.push_back('{0,    2'b00, 2'b00, 1'b0, 1'b0, 2'd1});
    tbl.push_back('{100,  2'b00, 2'b00, 1'b0, 1'b0, 2'd1});
    tbl.push_back('{101,  2'b11, 2'b00, 1'b0, 1'b0, 2'd1});
    tbl.push_back('{102,  2'b00, 2'b00, 1'b0, 1'b0, 2'd1});
    tbl.push_back('{1000, 2'b00, 2'b00, 1'b0, 1'b0, 2'd1});
    tbl.push_back('{1001, 2'b00, 2'b11, 1'b1, 1'b0, 2'd1});
    tbl.push_back('{1002, 2'b00, 2'b11, 1'b0, 1'b0, 2'd1});
    tbl.push_back('{2000, 2'b00, 2'b11, 1'b0, 1'b0, 2'd1});
    tbl.push_back('{2001, 2'b00, 2'b11, 1'b0, 1'b1, 2'd2});
    tbl.push_back('{2010, 2'b00, 2'b11, 1'b0, 1'b1, 2'd2});

    step(); step();
    arstn  = 1'b1;
    edge_n = 0;
    agc_pulses = 0;
    chk("rst_ctrlword", 32'(adc_ctrlword), 32'({2{DEF_CTRL_INIT}}));
    chk("rst_agc_data", 32'(agc_data), 32'(DEF_AGC_INIT));
    foreach (tbl[i]) begin
      goto_edge(tbl[i].at_edge);
      chk($sformatf("v%0d_ldctrl", i), 32'(adc_ldctrl), 32'(tbl[i].ld));
      chk($sformatf("v%0d_enable", i), 32'(adc_enable), 32'(tbl[i].en));
      chk($sformatf("v%0d_agc_load", i), 32'(agc_load), 32'(tbl[i].agc));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
      if (tbl[i].at_edge == 1001)
        chk("s1_agc_data", 32'(agc_data), 32'(DEF_AGC_INIT));
    end
    chk("s1_agc_pulses", 32'(agc_pulses), 32'd1);

    // ---------------- mask 01, start from DONE ----------------
    ch_mask = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    base = edge_n;
    chk("s2_state_run", 32'(state), 32'd1);
    chk("s2_enable_clr", 32'(adc_enable), 32'd0);
    b1_seen = 0;
    goto_edge(base + 101);
    chk("s2_ldctrl", 32'(adc_ldctrl), 32'b01);
    goto_edge(base + 1001);
    chk("s2_enable", 32'(adc_enable), 32'b01);
    goto_edge(base + 2001);
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_bit1_quiet", 32'(b1_seen), 32'd0);

    // ---------------- looping ----------------
    ch_mask = 2'b11; loop_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    base = edge_n;
    goto_edge(base + 1001);
    en_low = 0;
    goto_edge(base + 2000);
    chk("s3_en_before_wrap", 32'(adc_enable), 32'b11);
    step();
    chk("s3_en_wrap1_low", 32'(adc_enable), 32'b00);
    chk("s3_state_loop", 32'(state), 32'd1);
    step();
    chk("s3_en_wrap1_back", 32'(adc_enable), 32'b11);
    goto_edge(base + 2101);
    chk("s3_ld_early", 32'(adc_ldctrl), 32'b00);
    step();
    chk("s3_ld_repulse", 32'(adc_ldctrl), 32'b11);
    goto_edge(base + 4002);
    chk("s3_en_wrap2_low", 32'(adc_enable), 32'b00);
    step();
    chk("s3_en_wrap2_back", 32'(adc_enable), 32'b11);
    goto_edge(base + 4100);
    chk("s3_en_low_cycles", 32'(en_low), 32'd2);
    chk("s3_done_low", 32'(done), 32'd0);

    // ---------------- abort / restart ----------------
    loop_en = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s4_abort_idle", 32'(state), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    base = edge_n;
    goto_edge(base + 500);
    abort = 1'b1; start = 1'b1;
    step();
    a_edge = edge_n;
    chk("s4_abort_state", 32'(state), 32'd0);
    chk("s4_abort_en", 32'(adc_enable), 32'd0);
    chk("s4_abort_done", 32'(done), 32'd0);
    step();
    chk("s4_abort_beats_start", 32'(state), 32'd0);
    abort = 1'b0; start = 1'b0;
    ld_pulses = 0;
    goto_edge(a_edge + 9);
    chk("s4_no_ld_idle", 32'(ld_pulses), 32'd0);
    chk("s4_still_idle", 32'(state), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    s2 = edge_n;
    chk("s4_restart_run", 32'(state), 32'd1);
    goto_edge(s2 + 100);
    chk("s4_ld_early", 32'(adc_ldctrl), 32'b00);
    step();
    chk("s4_ld_101", 32'(adc_ldctrl), 32'b11);

    // ---------------- agc_busy across T_AGC ----------------
    goto_edge(s2 + 980);
    agc_busy = 1'b1;
    goto_edge(s2 + 1000);
    agc_pulses = 0;
    step();
    chk("s5_held_while_busy", 32'(agc_load), 32'd0);
    goto_edge(s2 + 1030);
    agc_busy = 1'b0;
    step();
    chk("s5_load_after_busy", 32'(agc_load), 32'd1);
    chk("s5_load_data", 32'(agc_data), 32'(DEF_AGC_INIT));
    goto_edge(s2 + 1100);
    chk("s5_single_load", 32'(agc_pulses), 32'd1);

    // ---------------- runtime AGC writes ----------------
`ifdef ADC_SEQ_AGC_UPDATE_EN
    exp_upd = 12'h200;
    exp_upd_pulses = 1;
`else
    exp_upd = DEF_AGC_INIT;
    exp_upd_pulses = 0;
`endif
    agc_busy = 1'b1;
    step();
    agc_wr = 1'b1; agc_wdata = 12'h100;
    step();
    agc_wdata = 12'h200;
    step();
    agc_wr = 1'b0;
    step(); step();
    agc_pulses = 0;
    chk("s6_no_load_busy", 32'(agc_load), 32'd0);
    chk("s6_data_before", 32'(agc_data), 32'(DEF_AGC_INIT));
    agc_busy = 1'b0;
    step();
    busy_edge = edge_n;
    chk("s6_load_pulse", 32'(agc_load), 32'(exp_upd_pulses));
    chk("s6_load_data", 32'(agc_data), 32'(exp_upd));
    goto_edge(busy_edge + 5);
    chk("s6_pulse_count", 32'(agc_pulses), 32'(exp_upd_pulses));
    chk("s6_data_after", 32'(agc_data), 32'(exp_upd));

    // ---------------- reset mid-sequence ----------------
    arstn = 1'b0;
    step();
    chk("s7_rst_state", 32'(state), 32'd1);
    chk("s7_rst_en", 32'(adc_enable), 32'd0);
    chk("s7_rst_ld", 32'(adc_ldctrl), 32'd0);
    chk("s7_rst_agc", 32'(agc_load), 32'd0);
    chk("s7_rst_done", 32'(done), 32'd0);
    chk("s7_rst_data", 32'(agc_data), 32'(DEF_AGC_INIT));
    arstn = 1'b1;
    step();

    chk("never_consec_agc", 32'(agc_consec), 32'd0);
    chk("never_consec_ld", 32'(ld_consec), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sequencer.md
# adc_sequencer

Parametrised master sequencer for the ADC/AGC front end. It issues the ADC control-word load and enable for N channels and the AGC DAC load at programmable cycle counts after reset or restart. It also supports single-shot or looping operation, abort/restart and per-channel masking. It sits at top level between the reset/PLL domain and the `adc_if` instances and the AGC `spiMasterWrite`.

## Interface
Parameters:
- `NUM_CH`, 2: number of ADC channels.
- `CNT_W`, 32: event counter width.
- `CTRL_W`, 10: ADC control-word width.
- `AGC_W`, 12: AGC DAC code width.
- `CTRL_INIT`, 10'b0000100100: control word driven to every channel.
- `AGC_INIT`, 12'h333: AGC code after reset.
- `T_LDCTRL`, 100: count at which `adc_ldctrl` pulses.
- `T_ENABLE`, 1000: count at which `adc_enable` rises.
- `T_AGC`, 1000: count at which `agc_load` pulses.
- `T_END`, 1_000_000_000: terminal count.

Ports:
- `clk` in 1: system clock (PLL GLA).
- `arstn` in 1: reset, synchronous, active-low.
- `start` in 1: restart the sequence from IDLE or DONE.
- `abort` in 1: stop immediately and return to IDLE.
- `loop_en` in 1: repeat the sequence at `T_END` instead of stopping.
- `ch_mask` in NUM_CH: per-channel participation, latched on sequence start.
- `agc_busy` in 1: AGC SPI transfer in progress.
- `agc_wr` in 1: runtime AGC code write strobe.
- `agc_wdata` in AGC_W: runtime AGC code.
- `adc_ldctrl` out NUM_CH: one-cycle control-word load pulses.
- `adc_enable` out NUM_CH: ADC enable levels.
- `adc_ctrlword` out NUM_CH*CTRL_W: control words, channel 0 in the LSBs.
- `agc_load` out 1: one-cycle AGC load pulse.
- `agc_data` out AGC_W: AGC code.
- `done` out 1: high in DONE.
- `state` out 2: current state, for debug/LEDs.

## Operation
- States are IDLE=0, RUN=1, DONE=2.
- Reset puts the block in RUN with cnt=0 and `ch_mask` latched, so the sequence starts automatically after reset.
- In RUN, cnt increments by 1 each cycle.
  - cnt==`T_LDCTRL`: `adc_ldctrl` pulses on masked channels.
  - cnt==`T_ENABLE`: `adc_enable` is set on masked channels.
  - cnt==`T_AGC`: an AGC load is requested.
- cnt==`T_END` with `loop_en`=1: cnt goes to 0, all enables clear for that cycle and the sequence repeats. The mask is re-latched.
- cnt==`T_END` with `loop_en`=0: the block enters DONE. cnt holds and enables stay set.
- `abort`: state goes to IDLE, cnt=0, enables clear and pending pulses are dropped. `abort` has priority over `start` and over every event.
- `start` in IDLE or DONE: state goes to RUN, cnt=0 and the mask is latched. `start` in RUN is ignored.
- AGC load is issued only when `agc_busy`=0. Otherwise the request stays pending and issues on the first cycle `agc_busy`=0.
- Parameter legality: `T_LDCTRL` < `T_ENABLE` ≤ `T_END`, `T_AGC` < `T_END`, and `T_END` < 2^CNT_W. Any violation is an elaboration error.

## Timing
- All outputs are registered.
- An event at cnt==T produces its output change at the next clock edge, i.e. latency 1.
- `adc_ldctrl` and `agc_load` are exactly 1 cycle high and never high on consecutive cycles.
- Reset values:
  - `adc_ldctrl`=0, `adc_enable`=0, `agc_load`=0.
  - `agc_data`=`AGC_INIT`, `adc_ctrlword`={NUM_CH{`CTRL_INIT`}}.
  - `done`=0, `state`=RUN.
- Reset asserted mid-sequence: all of the above apply at the next edge and any pending AGC request is cleared.
- Loop wrap: `adc_enable` is low for exactly 1 cycle between iterations.

## Configuration
- `ADC_SEQ_AGC_UPDATE_EN` defined:
  - `agc_wr` captures `agc_wdata` into a pending register and raises a pending flag.
  - The pending value is written to `agc_data` and `agc_load` pulses on the first cycle `agc_busy`=0, in any state.
  - A second `agc_wr` before issue overwrites the pending data; only the latest code is loaded.
  - A pending update coincident with the `T_AGC` event merges into a single pulse carrying the latest code.
- `ADC_SEQ_AGC_UPDATE_EN` undefined:
  - `agc_wr` and `agc_wdata` are ignored and `agc_data` is constant `AGC_INIT`.

## Structure
- Package `adc_seq_pkg` holds the state enum (`seq_state_t`) and the default timing/code constants, which are shared with the top level and the bench.
- Sub-module `adc_seq_agc_arb` holds the AGC request/pending/busy arbitration, including the macro-gated update path.

## Test plan
- Reset release, `ch_mask`=2'b11, `loop_en`=0, T_END=2000:
  - `adc_ldctrl`=2'b11 for one cycle at edge 101.
  - `adc_enable`=2'b11 from edge 1001.
  - `agc_load` once at edge 1001 with `agc_data`=12'h333.
  - `done`=1 from edge 2001.
- `ch_mask`=2'b01, `start` from DONE: only bit 0 pulses/enables; bit 1 stays 0 throughout.
- `loop_en`=1, T_END=2000: enable drops for exactly 1 cycle every 2001 cycles and `adc_ldctrl` re-pulses 100 cycles after each wrap.
- `abort` at cnt=500, then `start` 10 cycles later: no ldctrl pulse while aborted; the ldctrl pulse lands 101 cycles after `start`.
- `agc_busy` held high over `T_AGC` for 50 cycles: `agc_load` is issued on the first cycle after `agc_busy` falls, exactly once.
- Macro on: `agc_wr` 12'h100 then 12'h200 while busy, then busy falls: a single `agc_load` with `agc_data`=12'h200. Macro off: `agc_data` stays 12'h333.
